seq_timer_ctrl: RTL and testbench

Sequencing controller for a modulo-(FINAL+1) period counter. Latches a terminal value and repeat count on a start pulse, runs the counter for a programmed number of periods (or indefinitely), and emits a per-period tick and an end-of-sequence done pulse. Sits between software-visible configuration and any datapath that needs timed enables, such as blink or PWM frames and scan strobes.

---
 rtl/seq_timer_pkg.sv | 17 +
 rtl/seq_timer_period_counter.sv | 47 ++++
 rtl/seq_timer_ctrl.sv | 138 +++++++++++++
 tb/tb_seq_timer_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_timer_pkg.sv
// seq_timer_pkg: shared state encoding and default widths for seq_timer_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_timer_pkg;

  // Default counter width (N) and repeat-count width (R).
  localparam int unsigned SEQ_N = 4;
  localparam int unsigned SEQ_R = 4;

  // Controller state encoding. HOLD is only reachable when SEQ_TIMER_PAUSE_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/seq_timer_period_counter.sv
// period_counter: N-bit up counter that wraps to 0 after reaching a terminal value.
// Latency: q_o updates on the edge after clr_i/en_i; wrap_o is combinational from q_o and term_i.
// Backpressure: none; en_i low simply holds the count.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clr_i       synchronous clear to 0 (wins over en_i)
//   en_i        advance the count this cycle
//   term_i      terminal value; the count runs 0..term_i
//   q_o         current count
//   wrap_o      q_o == term_i, i.e. the next advance wraps to 0
module period_counter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] term_i,
  output logic [N-1:0] q_o,
  output logic         wrap_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  assign wrap_o = (q_q == term_i);
  assign q_o    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = wrap_o ? '0 : q_q + {{(N-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/seq_timer_ctrl.sv
// seq_timer_ctrl: sequences a modulo-(final_value+1) period counter for repeat_count+1 periods
//   (or forever when periodic), emitting a per-period tick and an end-of-sequence done.
// Latency: start sampled at edge k gives busy=1, q=0 after edge k; first tick in the cycle after edge k+fv.
// Backpressure: start is ignored while busy; stop aborts from any state. Optional pause
//   (macro SEQ_TIMER_PAUSE_EN) moves RUN into HOLD on the next edge and back when released.
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   start, stop             sequence request (IDLE only) and abort (any state, highest priority)
//   periodic, final_value,  configuration, captured into shadow registers with start
//   repeat_count
//   pause                   freeze request (only with SEQ_TIMER_PAUSE_EN)
//   q, busy, tick, done,    current count, RUN/HOLD indicator, period tick, last-period tick,
//   reps_left               periods remaining after the current one
module seq_timer_ctrl
  import seq_timer_pkg::*;
#(
  parameter int unsigned N = SEQ_N,
  parameter int unsigned R = SEQ_R
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [N-1:0] final_value,
  input  logic [R-1:0] repeat_count,
`ifdef SEQ_TIMER_PAUSE_EN
  input  logic         pause,
`endif
  output logic [N-1:0] q,
  output logic         busy,
  output logic         tick,
  output logic         done,
  output logic [R-1:0] reps_left
);

  state_t       state_q, state_d;
  logic [N-1:0] fv_q, fv_d;
  logic [R-1:0] rc_q, rc_d;
  logic         per_q, per_d;
  logic [R-1:0] reps_q, reps_d;

  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_wrap;

  period_counter #(.N(N)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (fv_q),
    .q_o    (q),
    .wrap_o (cnt_wrap)
  );

  // A stop cycle never reports a tick or done, even when q sits on the terminal value.
  assign tick      = (state_q == RUN) && cnt_wrap && !stop;
  assign done      = tick && (reps_q == '0);
  assign busy      = (state_q == RUN) || (state_q == HOLD);
  assign reps_left = reps_q;

  always_comb begin
    state_d = state_q;
    fv_d    = fv_q;
    rc_d    = rc_q;
    per_d   = per_q;
    reps_d  = reps_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      reps_d  = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            fv_d    = final_value;
            rc_d    = repeat_count;
            per_d   = periodic;
            reps_d  = repeat_count;
            cnt_clr = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          // The counter advances in every RUN cycle; pause only changes state at this edge,
          // so the freeze starts in the following cycle.
          cnt_en = 1'b1;
          if (cnt_wrap) begin
            if (reps_q != '0) begin
              reps_d = reps_q - {{(R-1){1'b0}}, 1'b1};
            end else if (per_q) begin
              reps_d = rc_q;
            end else begin
              state_d = IDLE;
            end
          end
`ifdef SEQ_TIMER_PAUSE_EN
          if (pause && (state_d == RUN)) begin
            state_d = HOLD;
          end
`endif
        end
        HOLD: begin
`ifdef SEQ_TIMER_PAUSE_EN
          if (!pause) begin
            state_d = RUN;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fv_q    <= '0;
      rc_q    <= '0;
      per_q   <= 1'b0;
      reps_q  <= '0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      rc_q    <= rc_d;
      per_q   <= per_d;
      reps_q  <= reps_d;
    end
  end

endmodule

// File: tb/tb_seq_timer_ctrl.sv
// tb_seq_timer_ctrl: directed self-checking bench for seq_timer_ctrl.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_seq_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [3:0] final_value;
  logic [3:0] repeat_count;
  logic       pause;
  logic [3:0] q;
  logic       busy;
  logic       tick;
  logic       done;
  logic [3:0] reps_left;

  int tests;
  int fails;

  seq_timer_ctrl #(.N(4), .R(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .periodic     (periodic),
    .final_value  (final_value),
    .repeat_count (repeat_count),
`ifdef SEQ_TIMER_PAUSE_EN
    .pause        (pause),
`endif
    .q            (q),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .reps_left    (reps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input logic eb, input int eq,
                         input logic et, input logic ed, input int er);
    chk($sformatf("%s c%0d busy", tag, c), 8'(busy), 8'(eb));
    chk($sformatf("%s c%0d q", tag, c), 8'(q), 8'(eq));
    chk($sformatf("%s c%0d tick", tag, c), 8'(tick), 8'(et));
    chk($sformatf("%s c%0d done", tag, c), 8'(done), 8'(ed));
    chk($sformatf("%s c%0d reps", tag, c), 8'(reps_left), 8'(er));
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] fv, input logic [3:0] rc, input logic per);
    final_value  = fv;
    repeat_count = rc;
    periodic     = per;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    periodic = 1'b0;
    final_value = 4'd0;
    repeat_count = 4'd0;
    pause = 1'b0;

    #12;
    chk_all("reset", 0, 1'b0, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_all("idle", 0, 1'b0, 0, 1'b0, 1'b0, 0);

    // fv=5 rc=2 one-shot: ticks at 6,12,18, done at 18, busy falls at 19.
    go(4'd5, 4'd2, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      if (c <= 18)
        chk_all("seqA", c, 1'b1, (c - 1) % 6, (c % 6) == 0, c == 18, 2 - (c - 1) / 6);
      else
        chk_all("seqA", c, 1'b0, 0, 1'b0, 1'b0, 0);
      if (c < 19) step();
    end

    // Start in the first IDLE cycle: fv=0 rc=3 ticks 4 cycles in a row.
    go(4'd0, 4'd3, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4)
        chk_all("fv0", c, 1'b1, 0, 1'b1, c == 4, 4 - c);
      else
        chk_all("fv0", c, 1'b0, 0, 1'b0, 1'b0, 0);
      if (c < 5) step();
    end

    // fv=3 rc=0 periodic: tick and done every 4th cycle, then stop on a would-be tick.
    go(4'd3, 4'd0, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      chk_all("per", c, 1'b1, (c - 1) % 4, (c % 4) == 0, (c % 4) == 0, 0);
      step();
    end
    stop = 1'b1;
    #1;
    chk_all("stopcyc", 12, 1'b1, 3, 1'b0, 1'b0, 0);
    step();
    stop = 1'b0;
    #1;
    chk_all("stopped", 13, 1'b0, 0, 1'b0, 1'b0, 0);

    // start together with stop in IDLE is dropped.
    final_value = 4'd1;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    #1;
    chk_all("startstop", 0, 1'b0, 0, 1'b0, 1'b0, 0);
    step();
    chk_all("startstop", 1, 1'b0, 0, 1'b0, 1'b0, 0);

    // Second start mid-run with new config is ignored; period stays 6.
    go(4'd5, 4'd0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) begin
        final_value = 4'd9;
        repeat_count = 4'd3;
        periodic = 1'b1;
        start = 1'b1;
      end
      if (c == 3) start = 1'b0;
      #1;
      if (c <= 6)
        chk_all("ignore", c, 1'b1, c - 1, c == 6, c == 6, 0);
      else
        chk_all("ignore", c, 1'b0, 0, 1'b0, 1'b0, 0);
      if (c < 7) step();
    end

    // Asynchronous reset mid-period at q=3.
    go(4'd5, 4'd1, 1'b0);
    step();
    step();
    step();
    chk_all("prerst", 4, 1'b1, 3, 1'b0, 1'b0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("asyncrst", 0, 1'b0, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    go(4'd2, 4'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      if (c <= 3)
        chk_all("postrst", c, 1'b1, c - 1, c == 3, c == 3, 0);
      else
        chk_all("postrst", c, 1'b0, 0, 1'b0, 1'b0, 0);
      if (c < 4) step();
    end

`ifdef SEQ_TIMER_PAUSE_EN
    // pause high in cycles 2..5: q holds at 2 from cycle 3 to 7, tick moves from 6 to 10.
    go(4'd5, 4'd0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      int eq;
      pause = (c >= 2) && (c <= 5);
      #1;
      eq = (c <= 2) ? c - 1 : (c <= 7) ? 2 : c - 5;
      if (c <= 10)
        chk_all("pause", c, 1'b1, eq, c == 10, c == 10, 0);
      else
        chk_all("pause", c, 1'b0, 0, 1'b0, 1'b0, 0);
      if (c < 11) step();
    end
    pause = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
